// File: rtl/uart_recv.sv
// 8N1 UART receiver: two-flop synchronizer, falling-edge start detect, mid-bit sampling,
// one-cycle strobes for a good byte (flag_out) or a low stop bit (frame_err).
module uart_recv #(
  parameter int unsigned CLK  = 50000000,
  parameter int unsigned BAUD = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       UART_rx,
  output logic [7:0] data_out,
  output logic       flag_out,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned Baud_Clk = CLK / BAUD;
  localparam int unsigned HALF     = Baud_Clk / 2;
  localparam int unsigned CW       = $clog2(Baud_Clk);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(Baud_Clk - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_baud_q, cnt_baud_d;
  logic [2:0]    cnt_bit_q, cnt_bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          flag_q, flag_d;
  logic          ferr_q, ferr_d;

  logic rx_s1_q, rx_sync_q, rx_d_q;
  logic fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_s1_q   <= UART_rx;
      rx_sync_q <= rx_s1_q;
      rx_d_q    <= rx_sync_q;
    end
  end

  assign fall = ~rx_sync_q & rx_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_baud_q <= '0;
      cnt_bit_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      flag_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_baud_q <= cnt_baud_d;
      cnt_bit_q  <= cnt_bit_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      flag_q     <= flag_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_baud_d = cnt_baud_q;
    cnt_bit_d  = cnt_bit_q;
    shift_d    = shift_q;
    data_d     = data_q;
    flag_d     = 1'b0;
    ferr_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d    = START;
          cnt_baud_d = '0;
        end
      end

      // Half a bit in: a line that is high again means the start was a glitch.
      START: begin
        if (cnt_baud_q == HALF_LAST) begin
          cnt_baud_d = '0;
          cnt_bit_d  = '0;
          state_d    = rx_sync_q ? IDLE : DATA;
        end else begin
          cnt_baud_d = cnt_baud_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_baud_q == BAUD_LAST) begin
          shift_d[cnt_bit_q] = rx_sync_q;
          cnt_baud_d         = '0;
          if (cnt_bit_q == 3'd7) begin
            cnt_bit_d = '0;
            state_d   = STOP;
          end else begin
            cnt_bit_d = cnt_bit_q + 1'b1;
          end
        end else begin
          cnt_baud_d = cnt_baud_q + 1'b1;
        end
      end

      // Leaving at mid-stop-bit lets IDLE catch a start edge that follows with no gap.
      STOP: begin
        if (cnt_baud_q == BAUD_LAST) begin
          cnt_baud_d = '0;
          state_d    = IDLE;
          if (rx_sync_q) begin
            data_d = shift_q;
            flag_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_baud_d = cnt_baud_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign data_out  = data_q;
  assign flag_out  = flag_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// Bench for uart_recv: drives 8N1 frames on the pin and compares strobes, data and
// latency against expectations derived from the frame contents and bit timing.
`timescale 1ns/1ps
module tb_uart_recv;

  localparam int unsigned CLK  = 50000000;
  localparam int unsigned BAUD = 115200;
  localparam int unsigned B    = CLK / BAUD;
  localparam int unsigned H    = B / 2;
  localparam int LAT = 3 + int'(H) + 9 * int'(B);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       UART_rx = 1'b1;
  logic [7:0] data_out;
  logic       flag_out, frame_err, busy;

  uart_recv #(.CLK(CLK), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .UART_rx(UART_rx),
    .data_out(data_out), .flag_out(flag_out), .frame_err(frame_err), .busy(busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit          err;
    logic [7:0]  data;
    int unsigned cyc;
  } ev_t;

  ev_t evq[$];
  ev_t exp_q[$];
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] last_good = 8'h00;
  bit prev_strobe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed strobes; also checks they are exclusive and never wider than one cycle.
  always @(negedge clk) begin
    if (flag_out || frame_err) begin
      ev_t e;
      checks++;
      if ((flag_out && frame_err) || prev_strobe) begin
        errors++;
        $display("FAIL strobe_shape: flag=%0b ferr=%0b prev=%0b, required single exclusive pulse",
                 flag_out, frame_err, prev_strobe);
      end
      e.err  = frame_err;
      e.data = data_out;
      e.cyc  = cyc;
      evq.push_back(e);
    end
    prev_strobe = flag_out || frame_err;
  end

  initial begin
    #(200000 * 20);
    $display("FAIL watchdog: simulation exceeded time limit, required self-termination");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: what a frame must produce, from its byte, stop bit and start time.
  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input int unsigned t0);
    ev_t e;
    e.err = !stop_ok;
    if (stop_ok) last_good = b;
    e.data = last_good;
    e.cyc  = t0 + LAT;
    exp_q.push_back(e);
  endtask

  // Caller is always 1 time unit after a rising edge; the task ends the same way.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, output int unsigned t0);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      UART_rx = bits[i];
      idle(B);
    end
    UART_rx = 1'b1;
  endtask

  task automatic compare_events(input string name);
    checks++;
    if (evq.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d strobes, required %0d", name, evq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < evq.size(); i++) begin
      int d;
      checks++;
      if (evq[i].err !== exp_q[i].err || evq[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL %s_ev%0d: got err=%0b data=%02h, required err=%0b data=%02h",
                 name, i, evq[i].err, evq[i].data, exp_q[i].err, exp_q[i].data);
      end
      d = int'(evq[i].cyc) - int'(exp_q[i].cyc);
      checks++;
      if (d < -2 || d > 2) begin
        errors++;
        $display("FAIL %s_lat%0d: got offset %0d cycles from expected %0d, required within 2",
                 name, i, d, LAT);
      end
    end
    evq.delete();
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    UART_rx = 1'b1;
    idle(5);
    rst = 1'b0;
    idle(1);
    checks++;
    if (data_out !== 8'h00 || flag_out !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got data=%02h flag=%0b ferr=%0b busy=%0b, required 00 0 0 0",
               data_out, flag_out, frame_err, busy);
    end
    idle(10000);
    checks++;
    if (data_out !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_state: got data=%02h busy=%0b, required 00 0", data_out, busy);
    end
    compare_events("idle");
  endtask

  task automatic test_single;
    int unsigned t0;
    fork
      send_frame(8'hA5, 1'b1, t0);
      begin
        idle(2000);
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_frame: got %0b mid-frame, required 1", busy);
        end
      end
    join
    model_frame(8'hA5, 1'b1, t0);
    idle(5);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after: got %0b after frame, required 0", busy);
    end
    compare_events("single");
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq [3] = '{8'h00, 8'hFF, 8'h3C};
    int unsigned t0;
    for (int i = 0; i < 3; i++) begin
      send_frame(seq[i], 1'b1, t0);
      model_frame(seq[i], 1'b1, t0);
    end
    idle(20);
    compare_events("b2b");
  endtask

  task automatic test_glitch;
    int unsigned t0;
    UART_rx = 1'b0;
    idle(100);
    UART_rx = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_hi: got %0b during start check, required 1", busy);
    end
    idle(200);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_lo: got %0b after start check, required 0", busy);
    end
    compare_events("glitch");
    send_frame(8'h5A, 1'b1, t0);
    model_frame(8'h5A, 1'b1, t0);
    idle(20);
    compare_events("after_glitch");
  endtask

  task automatic test_frame_err;
    int unsigned t0;
    send_frame(8'h81, 1'b0, t0);
    model_frame(8'h81, 1'b0, t0);
    idle(H);
    checks++;
    if (data_out !== last_good) begin
      errors++;
      $display("FAIL ferr_hold: got data=%02h, required %02h", data_out, last_good);
    end
    compare_events("ferr");
    send_frame(8'h42, 1'b1, t0);
    model_frame(8'h42, 1'b1, t0);
    idle(20);
    compare_events("after_ferr");
  endtask

  task automatic test_mid_reset;
    logic [7:0] b;
    int unsigned t0;
    b = 8'($urandom) | 8'h10;
    UART_rx = 1'b0;
    idle(B);
    for (int i = 0; i < 4; i++) begin
      UART_rx = b[i];
      idle(B);
    end
    UART_rx = b[4];
    idle(H);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    last_good = 8'h00;
    checks++;
    if (data_out !== 8'h00 || flag_out !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: got data=%02h flag=%0b ferr=%0b busy=%0b, required 00 0 0 0",
               data_out, flag_out, frame_err, busy);
    end
    UART_rx = 1'b1;
    idle(6 * B);
    compare_events("midreset");
    send_frame(8'hC3, 1'b1, t0);
    model_frame(8'hC3, 1'b1, t0);
    idle(20);
    compare_events("after_reset");
  endtask

  task automatic test_random;
    int unsigned t0;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] b;
      bit ok;
      int unsigned gap;
      b   = 8'($urandom);
      ok  = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, 300);
      if (!ok && gap < 5) gap = 5;
      send_frame(b, ok, t0);
      model_frame(b, ok, t0);
      if (gap > 0) idle(gap);
    end
    idle(20);
    compare_events("random");
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_recv.md
Name: uart_recv

Overview:
- 8N1 UART receiver. Converts the serial RS232-style line into parallel bytes and is the receive-side counterpart of the team's UART transmitter.
- Sits between the external RX pin and byte-consuming logic such as the command parser or the distance/echo path.
- Emits a one-cycle valid strobe per good byte and a one-cycle error strobe per bad stop bit.

Parameters:
- CLK, 50000000, system clock frequency in Hz.
- BAUD, 115200, line baud rate.
- Derived (localparam): Baud_Clk = CLK/BAUD (434 at defaults); HALF = Baud_Clk/2 (217). The counter is sized with $clog2(Baud_Clk).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- UART_rx  in  1  asynchronous serial input; idles high.
- data_out  out  8  last correctly received byte, LSB first on the line.
- flag_out  out  1  one-cycle pulse: data_out updated with a valid byte.
- frame_err  out  1  one-cycle pulse: stop bit sampled low; byte discarded.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Synchronizer:
  - UART_rx passes through 2 flops (rx_s1 -> rx_sync), then 1 delay flop (rx_d). All three reset to 1.
  - Falling edge = rx_sync==0 && rx_d==1.
- Reset (rst high at a clk edge):
  - state=IDLE, counters and shift register = 0.
  - data_out=8'h00, flag_out=0, frame_err=0, busy=0.
  - Reset mid-frame abandons the frame with no strobe.
- State machine:
  - IDLE: on a falling edge, go to START with cnt_baud=0. Otherwise stay.
  - START:
    - cnt_baud counts 0..HALF-1.
    - At cnt_baud==HALF-1, sample rx_sync. If 0, go to DATA with cnt_baud=0 and cnt_bit=0.
    - If 1, the start was a glitch: return to IDLE silently with no strobe.
  - DATA:
    - cnt_baud counts 0..Baud_Clk-1.
    - At Baud_Clk-1, sample rx_sync into shift[cnt_bit] (LSB first), then cnt_bit++ and cnt_baud=0.
    - After bit index 7, go to STOP.
  - STOP:
    - At cnt_baud==Baud_Clk-1, sample rx_sync.
    - If 1: data_out<=shift and flag_out<=1 for exactly 1 cycle.
    - If 0: frame_err<=1 for 1 cycle; data_out keeps its previous value.
    - Go to IDLE in both cases.
- Sampling and framing:
  - All samples land at mid-bit (HALF + k*Baud_Clk cycles after edge detection).
  - IDLE is re-entered at mid-stop-bit, so a following start edge is caught and back-to-back frames with no idle gap receive correctly.
- Latency:
  - flag_out/frame_err rise 1+HALF+9*Baud_Clk cycles after the edge-detect cycle.
  - That is 3+HALF+9*Baud_Clk cycles after the pin falls: 4126 at defaults.
  - The bench checks this within ±2 cycles.
- Strobes: flag_out and frame_err are never high together and never high for more than 1 cycle.
- Glitches:
  - A low pulse shorter than HALF cycles is rejected by the START check.
  - Line activity during DATA/STOP is sampled only at mid-bit; edges are ignored.
- Line low across reset release: produces a falling edge, then a frame is received, and its result depends only on the mid-bit samples. A line held low throughout samples a low stop bit and yields frame_err. This is the required behaviour.
- Break (line held low indefinitely): one frame_err, then IDLE. No further strobes until the line returns high and falls again.

Test Plan:
- Reset then idle line high for 10000 cycles -> data_out=8'h00, flag_out/frame_err/busy stay 0.
- Send 8'hA5 at 115200 (bit period 434 cycles) -> one flag_out pulse; data_out=8'hA5 on the pulse cycle; latency 4126±2 cycles from the start edge; busy high for the frame.
- Back-to-back 8'h00, 8'hFF, 8'h3C with no idle between stop and start -> three flag_out pulses; data_out sequence 00, FF, 3C; no frame_err.
- 100-cycle low glitch on an idle line -> no strobes; busy high ~217 cycles then 0. A following 8'h5A is received correctly.
- Frame 8'h81 with the stop bit driven low -> frame_err pulse only; data_out keeps the prior byte. The next good 8'h42 gives flag_out with data_out=8'h42.
- Assert rst for 1 cycle at mid-bit 4 of a frame -> all outputs 0 next cycle, no strobe for that frame. A fresh 8'hC3 afterwards is received correctly; in loopback with the team's transmitter, 256 random bytes match.
